// File: rtl/reqrsp_amo_unit.sv
// reqrsp_amo_unit: execution end of the reqrsp atomic protocol in front of a
// single-ported SRAM. Serves plain reads/writes, fetch-and-op atomics
// (Swap..Minu) and LR/SC, one transaction at a time, running every atomic as
// a locked read-modify-write.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   q_*                   request channel (valid/ready, addr, write, amo, data,
//                         strb, size)
//   p_*                   response channel (valid/ready, data, error)
//   mem_*                 SRAM port (req/gnt, addr, we, be, wdata, rvalid, rdata)
module reqrsp_amo_unit #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [3:0]           q_amo_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [7:0]           q_strb_i,
  input  logic [2:0]           q_size_i,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 p_error_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [7:0]           mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [3:0] AMO_NONE = 4'h0;
  localparam logic [3:0] AMO_SWAP = 4'h1;
  localparam logic [3:0] AMO_ADD  = 4'h2;
  localparam logic [3:0] AMO_AND  = 4'h3;
  localparam logic [3:0] AMO_OR   = 4'h4;
  localparam logic [3:0] AMO_XOR  = 4'h5;
  localparam logic [3:0] AMO_MAX  = 4'h6;
  localparam logic [3:0] AMO_MAXU = 4'h7;
  localparam logic [3:0] AMO_MIN  = 4'h8;
  localparam logic [3:0] AMO_MINU = 4'h9;
  localparam logic [3:0] AMO_LR   = 4'hA;
  localparam logic [3:0] AMO_SC   = 4'hB;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RSP} state_e;

  // Operands arrive already widened to 64 bits (sign- or zero-extended for a
  // 32-bit lane), so one 64-bit datapath covers both lane widths.
  function automatic logic [63:0] amo_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    case (op)
      AMO_SWAP: r = b;
      AMO_ADD:  r = a + b;
      AMO_AND:  r = a & b;
      AMO_OR:   r = a | b;
      AMO_XOR:  r = a ^ b;
      AMO_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      AMO_MAXU: r = (a > b) ? a : b;
      AMO_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      AMO_MINU: r = (a < b) ? a : b;
      default:  r = a;
    endcase
    return r;
  endfunction

  state_e                 state_r;
  logic                   ready_r;
  logic [AddrWidth-1:3]   word_addr_r;
  logic                   hi_r;
  logic [3:0]             amo_r;
  logic [2:0]             size_r;
  logic [63:0]            data_r;
  logic                   res_valid_r;
  logic [AddrWidth-1:3]   res_addr_r;
  logic [2:0]             res_size_r;

  logic                   req_err_s;
  logic [6:0]             size_mask_s;
  logic [7:0]             req_lane_be_s;
  logic                   is_fetch_s;
  logic                   sc_ok_s;
  logic [63:0]            sc_fail_s;
  logic [31:0]            a32_s, b32_s;
  logic                   sext_s;
  logic [63:0]            a_s, b_s, res_s, merged_s;

  // Ready is masked by reset so it is low while reset is held and high in the
  // first cycle after it drops.
  assign q_ready_o = ready_r & ~rst_i;

  // Request decode: error classification and lane byte mask.
  always_comb begin
    size_mask_s = (7'd1 << q_size_i) - 7'd1;
    req_err_s   = (q_amo_i > AMO_SC)
                | ((q_amo_i != AMO_NONE) && (q_size_i != 3'd2) && (q_size_i != 3'd3))
                | (|(q_addr_i[6:0] & size_mask_s));
    if (q_size_i == 3'd2) begin
      req_lane_be_s = q_addr_i[2] ? 8'hF0 : 8'h0F;
    end else begin
      req_lane_be_s = 8'hFF;
    end
  end

  // Read-modify-write datapath, fed straight from the returning read data so
  // the write request can be issued in the cycle after rvalid.
  always_comb begin
    is_fetch_s = (amo_r >= AMO_SWAP) && (amo_r <= AMO_MINU);
    sc_ok_s    = res_valid_r && (res_addr_r == word_addr_r) && (res_size_r == size_r);
    sc_fail_s  = (size_r == 3'd2 && hi_r) ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001;
    sext_s     = (amo_r == AMO_MAX) || (amo_r == AMO_MIN);
    a32_s      = hi_r ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    b32_s      = hi_r ? data_r[63:32] : data_r[31:0];
    if (size_r == 3'd3) begin
      a_s = mem_rdata_i;
      b_s = data_r;
    end else begin
      a_s = {{32{sext_s & a32_s[31]}}, a32_s};
      b_s = {{32{sext_s & b32_s[31]}}, b32_s};
    end
    res_s = amo_alu(amo_r, a_s, b_s);
    // Bytes outside the lane are written back unchanged; be masks them anyway.
    if (size_r == 3'd3) begin
      merged_s = res_s;
    end else if (hi_r) begin
      merged_s = {res_s[31:0], mem_rdata_i[31:0]};
    end else begin
      merged_s = {mem_rdata_i[63:32], res_s[31:0]};
    end
  end

  // Transaction FSM with registered outputs and the LR reservation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      ready_r     <= 1'b1;
      word_addr_r <= '0;
      hi_r        <= 1'b0;
      amo_r       <= AMO_NONE;
      size_r      <= 3'd0;
      data_r      <= 64'd0;
      res_valid_r <= 1'b0;
      res_addr_r  <= '0;
      res_size_r  <= 3'd0;
      p_valid_o   <= 1'b0;
      p_data_o    <= 64'd0;
      p_error_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 8'h00;
      mem_wdata_o <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (q_valid_i && ready_r) begin
            ready_r     <= 1'b0;
            word_addr_r <= q_addr_i[AddrWidth-1:3];
            hi_r        <= q_addr_i[2];
            amo_r       <= q_amo_i;
            size_r      <= q_size_i;
            data_r      <= q_data_i;
            p_data_o    <= 64'd0;
            mem_addr_o  <= {q_addr_i[AddrWidth-1:3], 3'b000};
            if (req_err_s) begin
              state_r   <= RSP;
              p_valid_o <= 1'b1;
              p_error_o <= 1'b1;
            end else if (q_amo_i == AMO_NONE && q_write_i) begin
              state_r     <= WR_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_be_o    <= q_strb_i;
              mem_wdata_o <= q_data_i;
            end else begin
              state_r   <= RD_REQ;
              mem_req_o <= 1'b1;
              mem_we_o  <= 1'b0;
              mem_be_o  <= req_lane_be_s;
            end
          end
        end
        RD_REQ: begin
          if (mem_gnt_i) begin
            state_r   <= RD_WAIT;
            mem_req_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            // p_data_o doubles as the old-value register.
            if (amo_r == AMO_SC) begin
              res_valid_r <= 1'b0;
              if (sc_ok_s) begin
                state_r     <= WR_REQ;
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_wdata_o <= data_r;
                p_data_o    <= 64'd0;
              end else begin
                state_r   <= RSP;
                p_valid_o <= 1'b1;
                p_data_o  <= sc_fail_s;
              end
            end else if (is_fetch_s) begin
              state_r     <= WR_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_wdata_o <= merged_s;
              p_data_o    <= mem_rdata_i;
            end else begin
              state_r   <= RSP;
              p_valid_o <= 1'b1;
              p_data_o  <= mem_rdata_i;
              if (amo_r == AMO_LR) begin
                res_valid_r <= 1'b1;
                res_addr_r  <= word_addr_r;
                res_size_r  <= size_r;
              end
            end
          end
        end
        WR_REQ: begin
          if (mem_gnt_i) begin
            state_r   <= RSP;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            p_valid_o <= 1'b1;
            // Any store to the reserved word breaks the reservation.
            if (res_addr_r == word_addr_r) begin
              res_valid_r <= 1'b0;
            end
          end
        end
        RSP: begin
          if (p_ready_i) begin
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            p_valid_o <= 1'b0;
            p_error_o <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
